// File: rtl/dmem_byte_responder.sv
// rtl/dmem_byte_responder.sv - single-outstanding data-memory responder (LW/LBU/SW/SB)
module dmem_byte_responder #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_byte_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_data_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_data_o,
  output logic        resp_err_o,
  input  logic        resp_yumi_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  localparam int DEPTH = 1 << ADDR_WIDTH;

  state_t state, next_state;

  logic [31:0]           mem [DEPTH];
  logic [31:0]           rd_word;
  logic [ADDR_WIDTH-1:0] idx_in, idx_q, wr_idx;
  logic [1:0]            lane_q;
  logic                  byte_op_q, write_q;
  logic [7:0]            sb_data_q, sel_byte;
  logic [31:0]           resp_data_q, resp_data_d, merged, wr_data;
  logic                  resp_err_q, resp_err_d;
  logic                  accept, misaligned, mem_we, mem_re;
  logic                  unused_addr;

  assign idx_in      = req_addr_i[ADDR_WIDTH+1:2];
  assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];
  assign misaligned  = !req_byte_i && (req_addr_i[1:0] != 2'b00);
  assign sel_byte    = rd_word[{lane_q, 3'b000} +: 8];

  always_comb begin
    merged = rd_word;
    merged[{lane_q, 3'b000} +: 8] = sb_data_q;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state   = state;
    req_ready_o  = 1'b0;
    resp_valid_o = 1'b0;
    accept       = 1'b0;
    mem_re       = 1'b0;
    mem_we       = 1'b0;
    wr_idx       = idx_in;
    wr_data      = req_data_i;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    case (state)
      IDLE: begin
        req_ready_o = 1'b1;
        accept      = req_valid_i;
        if (accept) begin
          resp_data_d = 32'h0;
          resp_err_d  = 1'b0;
          if (misaligned) begin
            resp_err_d = 1'b1;
            next_state = RESP;
          end else if (req_write_i && !req_byte_i) begin
            mem_we     = 1'b1;
            next_state = RESP;
          end else begin
            mem_re     = 1'b1;
            next_state = RD;
          end
        end
      end
      RD: begin
        // Only SB reaches RD with write set; it needs the merge cycle.
        if (write_q) begin
          next_state = WR;
        end else begin
          next_state  = RESP;
          resp_data_d = byte_op_q ? {24'h0, sel_byte} : rd_word;
        end
      end
      WR: begin
        mem_we     = 1'b1;
        wr_idx     = idx_q;
        wr_data    = merged;
        next_state = RESP;
      end
      RESP: begin
        resp_valid_o = 1'b1;
        if (resp_yumi_i) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
    // Reset must abandon an in-flight SB without touching memory.
    mem_we = mem_we && n_reset;
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      resp_data_q <= 32'h0;
      resp_err_q  <= 1'b0;
      idx_q       <= '0;
      lane_q      <= 2'b00;
      byte_op_q   <= 1'b0;
      write_q     <= 1'b0;
      sb_data_q   <= 8'h0;
    end else begin
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      if (accept) begin
        idx_q     <= idx_in;
        lane_q    <= req_addr_i[1:0];
        byte_op_q <= req_byte_i;
        write_q   <= req_write_i;
        sb_data_q <= req_data_i[7:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_idx] <= wr_data;
    if (mem_re) rd_word <= mem[idx_in];
  end

  assign resp_data_o = resp_valid_o ? resp_data_q : 32'h0;
  assign resp_err_o  = resp_valid_o ? resp_err_q : 1'b0;

endmodule

// File: tb/tb_dmem_byte_responder.sv
// tb/tb_dmem_byte_responder.sv - directed vector bench for dmem_byte_responder
module tb_dmem_byte_responder;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [31:0] req_addr, req_data;
  logic        resp_valid, resp_err, resp_yumi;
  logic [31:0] resp_data;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic        w;
    logic        b;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[19];

  always #5 clk = ~clk;

  dmem_byte_responder #(.ADDR_WIDTH(10)) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_write_i  (req_write),
    .req_byte_i   (req_byte),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_err_o   (resp_err),
    .resp_yumi_i  (resp_yumi)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic b, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_byte  = b;
    req_addr  = a;
    req_data  = d;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    rd = resp_data;
    er = resp_err;
    if (!resp_valid) lat = -1;
    resp_yumi = 1'b1;
    @(posedge clk);
    #1;
    resp_yumi = 1'b0;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    vecs[0]  = '{1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0, 1};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2};
    vecs[2]  = '{1'b1, 1'b0, 32'h00,   32'h11223344, 32'h0,        1'b0, 1};
    vecs[3]  = '{1'b1, 1'b1, 32'h02,   32'h00000055, 32'h0,        1'b0, 3};
    vecs[4]  = '{1'b0, 1'b0, 32'h00,   32'h0,        32'h11553344, 1'b0, 2};
    vecs[5]  = '{1'b0, 1'b1, 32'h03,   32'h0,        32'h00000011, 1'b0, 2};
    vecs[6]  = '{1'b0, 1'b1, 32'h01,   32'h0,        32'h00000033, 1'b0, 2};
    vecs[7]  = '{1'b1, 1'b0, 32'h04,   32'hCAFEF00D, 32'h0,        1'b0, 1};
    vecs[8]  = '{1'b0, 1'b0, 32'h06,   32'h0,        32'h0,        1'b1, 1};
    vecs[9]  = '{1'b0, 1'b0, 32'h04,   32'h0,        32'hCAFEF00D, 1'b0, 2};
    vecs[10] = '{1'b1, 1'b0, 32'h06,   32'h12345678, 32'h0,        1'b1, 1};
    vecs[11] = '{1'b0, 1'b0, 32'h04,   32'h0,        32'hCAFEF00D, 1'b0, 2};
    vecs[12] = '{1'b1, 1'b1, 32'h07,   32'h123456A5, 32'h0,        1'b0, 3};
    vecs[13] = '{1'b0, 1'b0, 32'h04,   32'h0,        32'hA5FEF00D, 1'b0, 2};
    vecs[14] = '{1'b0, 1'b1, 32'h04,   32'h0,        32'h0000000D, 1'b0, 2};
    vecs[15] = '{1'b1, 1'b0, 32'h1000, 32'h00000001, 32'h0,        1'b0, 1};
    vecs[16] = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h00000001, 1'b0, 2};
    vecs[17] = '{1'b1, 1'b1, 32'h1001, 32'h00000077, 32'h0,        1'b0, 3};
    vecs[18] = '{1'b0, 1'b0, 32'h0,    32'h0,        32'h00007701, 1'b0, 2};

    n_reset   = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h0;
    req_data  = 32'h0;
    resp_yumi = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset resp_valid", resp_valid, 0);
    check("reset resp_data", resp_data, 0);
    check("reset resp_err", resp_err, 0);
    n_reset = 1'b1;
    @(negedge clk);
    check("post-reset req_ready", req_ready, 1);

    for (int i = 0; i < 19; i++) begin
      do_req(vecs[i].w, vecs[i].b, vecs[i].addr, vecs[i].data, rd, er, lat);
      check($sformatf("vec%0d data", i), rd, vecs[i].exp_data);
      check($sformatf("vec%0d err", i), er, vecs[i].exp_err);
      check($sformatf("vec%0d latency", i), lat, vecs[i].exp_lat);
    end

    // Reset while an SB sits in WR: the write must be dropped.
    do_req(1'b1, 1'b0, 32'h8, 32'h11223344, rd, er, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_byte  = 1'b1;
    req_addr  = 32'h8;
    req_data  = 32'h000000AA;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_reset = 1'b0;
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    @(negedge clk);
    check("midsb resp_valid", resp_valid, 0);
    check("midsb req_ready", req_ready, 1);
    do_req(1'b0, 1'b0, 32'h8, 32'h0, rd, er, lat);
    check("midsb word intact", rd, 32'h11223344);

    // Yumi with no response pending must not disturb IDLE.
    @(negedge clk);
    resp_yumi = 1'b1;
    @(posedge clk);
    #1;
    resp_yumi = 1'b0;
    @(negedge clk);
    check("stray yumi ready", req_ready, 1);
    check("stray yumi valid", resp_valid, 0);

    // Backpressure: hold the LW response, offer a second request meanwhile.
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 32'h10;
    @(posedge clk);
    #1;
    req_addr = 32'h0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("bp latency", lat, 2);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("bp%0d valid", k), resp_valid, 1);
      check($sformatf("bp%0d data", k), resp_data, 32'hDEADBEEF);
      check($sformatf("bp%0d ready", k), req_ready, 0);
      @(negedge clk);
    end
    resp_yumi = 1'b1;
    @(posedge clk);
    #1;
    resp_yumi = 1'b0;
    @(negedge clk);
    check("bp ready after yumi", req_ready, 1);
    check("bp valid after yumi", resp_valid, 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!resp_valid && lat < 20);
    check("bp second latency", lat, 2);
    check("bp second data", resp_data, 32'h00007701);
    resp_yumi = 1'b1;
    @(posedge clk);
    #1;
    resp_yumi = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
